// File: rtl/ss2_datastack_ctrl.sv
// ---------------------------------------------------------------------------
// ss2_datastack_ctrl
// Command sequencer in front of the 16-bit data stack (ss2_datastack_16b).
// Takes one command at a time over a valid/ready handshake. Each command is
// turned into the short strobe sequence the stack needs. The block also
// tracks occupancy, rejects overflow/underflow/illegal commands and pulses a
// completion response.
//
// Optional feature macro: DSCTRL_STATS_EN
//   Adds the hwm output (high-water mark of depth since reset or FLUSH) and
//   the ops_done output (16-bit wrapping count of ok responses, FLUSH
//   included).
//
// Ports
//   CLK          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   cmd_valid    in   command present
//   cmd_op       in   0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 LOAD, 5 FLUSH, 6-7 illegal
//   cmd_src      in   TR source for PUSH/LOAD (1..4); 0 is reserved
//   cmd_ready    out  high only in IDLE
//   resp_valid   out  1-cycle completion pulse
//   resp_err     out  0 ok, 1 overflow, 2 underflow, 3 illegal
//   depth        out  current occupancy (0..DEPTH)
//   empty/full   out  depth==0 / depth==DEPTH
//   ds_dp_inc    out  stack pointer step: 00 hold, 01 +1, 10 -1
//   ds_regWrite  out  spill TR into the slot at the new pointer
//   ds_tr_write  out  TR write enable
//   ds_tr_src    out  TR source: 0 = stack read data (fill), 1..4 = cmd_src
//   ds_reset     out  active-high stack reset, 1-cycle pulse on FLUSH
//   hwm          out  (DSCTRL_STATS_EN only) high-water mark of depth
//   ops_done     out  (DSCTRL_STATS_EN only) ok-response counter
// ---------------------------------------------------------------------------
module ss2_datastack_ctrl #(
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = 5
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [2:0]         cmd_op,
    input  logic [2:0]         cmd_src,
    output logic               cmd_ready,
    output logic               resp_valid,
    output logic [1:0]         resp_err,
    output logic [DEPTH_W-1:0] depth,
    output logic               empty,
    output logic               full,
    output logic [1:0]         ds_dp_inc,
    output logic               ds_regWrite,
    output logic               ds_tr_write,
    output logic [2:0]         ds_tr_src,
    output logic               ds_reset
`ifdef DSCTRL_STATS_EN
    ,
    output logic [DEPTH_W-1:0] hwm,
    output logic [15:0]        ops_done
`endif
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_FLUSH = 3'd5;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_OVER  = 2'd1;
    localparam logic [1:0] ERR_UNDER = 2'd2;
    localparam logic [1:0] ERR_ILL   = 2'd3;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    typedef enum logic [3:0] {
        IDLE, PUSH_SPILL, PUSH_LOAD, POP_FILL, POP_DEC,
        DUP_SPILL, LOAD_TR, FLUSH_RST, RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [2:0]         src_reg, src_next;
    logic [1:0]         err_reg, err_next;
    logic [DEPTH_W-1:0] depth_reg, depth_next;
    logic [1:0]         accept_err;
    logic               is_empty, is_full;
    logic               resp_ok;

    assign is_empty = (depth_reg == '0);
    assign is_full  = (depth_reg == DEPTH_MAX);
    // True on the cycle the FSM leaves RESP for a successful command.
    assign resp_ok  = (state_reg == RESP) && (err_reg == ERR_OK);

    // Error classification at accept time. An illegal encoding takes
    // precedence over capacity checks.
    always_comb begin
        accept_err = ERR_OK;
        if (cmd_op > OP_FLUSH)
            accept_err = ERR_ILL;
        else if ((cmd_op == OP_PUSH || cmd_op == OP_LOAD) && cmd_src == 3'd0)
            accept_err = ERR_ILL;
        else if ((cmd_op == OP_PUSH || cmd_op == OP_DUP) && is_full)
            accept_err = ERR_OVER;
        else if ((cmd_op == OP_POP || cmd_op == OP_DUP || cmd_op == OP_LOAD) && is_empty)
            accept_err = ERR_UNDER;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            op_reg    <= OP_NOP;
            src_reg   <= 3'd0;
            err_reg   <= ERR_OK;
            depth_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            src_reg   <= src_next;
            err_reg   <= err_next;
            depth_reg <= depth_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        src_next   = src_reg;
        err_next   = err_reg;
        depth_next = depth_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    op_next    = cmd_op;
                    src_next   = cmd_src;
                    err_next   = accept_err;
                    state_next = RESP;
                    if (accept_err == ERR_OK) begin
                        case (cmd_op)
                            OP_PUSH:  state_next = is_empty ? PUSH_LOAD : PUSH_SPILL;
                            // Popping the last entry only discards TR.
                            OP_POP:   state_next = (depth_reg > DEPTH_W'(1)) ? POP_FILL : RESP;
                            OP_DUP:   state_next = DUP_SPILL;
                            OP_LOAD:  state_next = LOAD_TR;
                            OP_FLUSH: state_next = FLUSH_RST;
                            default:  state_next = RESP;
                        endcase
                    end
                end
            end
            PUSH_SPILL: state_next = PUSH_LOAD;
            POP_FILL:   state_next = POP_DEC;
            PUSH_LOAD, POP_DEC, DUP_SPILL, LOAD_TR, FLUSH_RST: state_next = RESP;
            RESP: begin
                state_next = IDLE;
                if (err_reg == ERR_OK) begin
                    case (op_reg)
                        OP_PUSH, OP_DUP: depth_next = depth_reg + DEPTH_W'(1);
                        OP_POP:          depth_next = depth_reg - DEPTH_W'(1);
                        OP_FLUSH:        depth_next = '0;
                        default:         depth_next = depth_reg;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        cmd_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = ERR_OK;
        ds_dp_inc   = 2'b00;
        ds_regWrite = 1'b0;
        ds_tr_write = 1'b0;
        ds_tr_src   = 3'd0;
        ds_reset    = 1'b0;
        case (state_reg)
            IDLE:       cmd_ready = 1'b1;
            PUSH_SPILL, DUP_SPILL: begin
                ds_dp_inc   = 2'b01;
                ds_regWrite = 1'b1;
            end
            PUSH_LOAD, LOAD_TR: begin
                ds_tr_write = 1'b1;
                ds_tr_src   = src_reg;
            end
            POP_FILL:   ds_tr_write = 1'b1;
            POP_DEC:    ds_dp_inc   = 2'b10;
            FLUSH_RST:  ds_reset    = 1'b1;
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_reg;
            end
            default: ;
        endcase
    end

    assign depth = depth_reg;
    assign empty = is_empty;
    assign full  = is_full;

`ifdef DSCTRL_STATS_EN
    logic [DEPTH_W-1:0] hwm_reg;
    logic [15:0]        ops_done_reg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hwm_reg      <= '0;
            ops_done_reg <= 16'd0;
        end else if (resp_ok) begin
            ops_done_reg <= ops_done_reg + 16'd1;
            if (op_reg == OP_FLUSH)
                hwm_reg <= '0;
            else if (depth_next > hwm_reg)
                hwm_reg <= depth_next;
        end
    end

    assign hwm      = hwm_reg;
    assign ops_done = ops_done_reg;
`endif

endmodule

// File: tb/tb_ss2_datastack_ctrl.sv
module tb_ss2_datastack_ctrl;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 3;

    logic               CLK;
    logic               reset;
    logic               cmd_valid;
    logic [2:0]         cmd_op;
    logic [2:0]         cmd_src;
    logic               cmd_ready;
    logic               resp_valid;
    logic [1:0]         resp_err;
    logic [DEPTH_W-1:0] depth;
    logic               empty;
    logic               full;
    logic [1:0]         ds_dp_inc;
    logic               ds_regWrite;
    logic               ds_tr_write;
    logic [2:0]         ds_tr_src;
    logic               ds_reset;
`ifdef DSCTRL_STATS_EN
    logic [DEPTH_W-1:0] hwm;
    logic [15:0]        ops_done;
`endif

    ss2_datastack_ctrl #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_src     (cmd_src),
        .cmd_ready   (cmd_ready),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .ds_dp_inc   (ds_dp_inc),
        .ds_regWrite (ds_regWrite),
        .ds_tr_write (ds_tr_write),
        .ds_tr_src   (ds_tr_src),
        .ds_reset    (ds_reset)
`ifdef DSCTRL_STATS_EN
        ,
        .hwm         (hwm),
        .ops_done    (ops_done)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Strobe signature: {dp_inc[1:0], regWrite, tr_write, tr_src[2:0], ds_reset}
    localparam logic [7:0] S_NONE  = 8'h00;
    localparam logic [7:0] S_SPILL = 8'h60;
    localparam logic [7:0] S_FILL  = 8'h10;
    localparam logic [7:0] S_DEC   = 8'h80;
    localparam logic [7:0] S_FLUSH = 8'h01;

    function automatic logic [7:0] s_load(input logic [2:0] src);
        return {2'b00, 1'b0, 1'b1, src, 1'b0};
    endfunction

    function automatic logic [7:0] sig();
        return {ds_dp_inc, ds_regWrite, ds_tr_write, ds_tr_src, ds_reset};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string      nm;
        logic [2:0] op;
        logic [2:0] src;
        logic [1:0] err;
        int         lat;
        logic [7:0] s0;
        logic [7:0] s1;
        int         dep;
    } vec_t;

    vec_t tbl[$];

    // Issue one command, follow it to its response and check the strobes,
    // latency, error code and the resulting idle state.
    task automatic do_cmd(input string nm, input logic [2:0] op, input logic [2:0] src,
                          input logic [1:0] e, input int lat, input logic [7:0] s0,
                          input logic [7:0] s1, input int dep);
        int n;
        logic [7:0] sg;
        @(negedge CLK);
        chk({nm, "/ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_src = src; cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src = 3'd0;
        n = 0;
        sg = 8'h00;
        while (n < 10) begin
            @(negedge CLK);
            n++;
            sg = sig();
            if (resp_valid) break;
            if (n == 1)      chk({nm, "/strobe1"}, 32'(sg), 32'(s0));
            else if (n == 2) chk({nm, "/strobe2"}, 32'(sg), 32'(s1));
            else             chk({nm, "/strobeN"}, 32'(sg), 32'(S_NONE));
        end
        chk({nm, "/latency"}, 32'(n), 32'(lat));
        chk({nm, "/resp_err"}, 32'(resp_err), 32'(e));
        chk({nm, "/resp_strobe"}, 32'(sg), 32'(S_NONE));
        chk({nm, "/ready_resp"}, 32'(cmd_ready), 32'd0);
        @(negedge CLK);
        chk({nm, "/depth"}, 32'(depth), 32'(dep));
        chk({nm, "/empty"}, 32'(empty), 32'(dep == 0));
        chk({nm, "/full"}, 32'(full), 32'(dep == DEPTH));
        chk({nm, "/resp_clr"}, 32'(resp_valid), 32'd0);
        $display("txn %s op=%0d src=%0d err=%0d lat=%0d depth=%0d", nm, op, src, resp_err, n, depth);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_src = 3'd0;

        //         name         op  src err lat s0            s1         depth
        tbl.push_back('{"push0",   1, 2, 0, 2, s_load(3'd2), S_NONE,     1});
        tbl.push_back('{"push1",   1, 4, 0, 3, S_SPILL,     s_load(3'd4), 2});
        tbl.push_back('{"push2",   1, 1, 0, 3, S_SPILL,     s_load(3'd1), 3});
        tbl.push_back('{"push3",   1, 3, 0, 3, S_SPILL,     s_load(3'd3), 4});
        tbl.push_back('{"push_ovf",1, 1, 1, 1, S_NONE,      S_NONE,     4});
        tbl.push_back('{"dup_ovf", 3, 0, 1, 1, S_NONE,      S_NONE,     4});
        tbl.push_back('{"pop4",    2, 0, 0, 3, S_FILL,      S_DEC,      3});
        tbl.push_back('{"pop3",    2, 0, 0, 3, S_FILL,      S_DEC,      2});
        tbl.push_back('{"pop2",    2, 0, 0, 3, S_FILL,      S_DEC,      1});
        tbl.push_back('{"pop1",    2, 0, 0, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"pop_unf", 2, 0, 2, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"op6",     6, 1, 3, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"op7",     7, 2, 3, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"load_unf",4, 2, 2, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"dup_unf", 3, 0, 2, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"nop",     0, 0, 0, 1, S_NONE,      S_NONE,     0});
        tbl.push_back('{"push_e",  1, 1, 0, 2, s_load(3'd1), S_NONE,    1});
        tbl.push_back('{"load_s0", 4, 0, 3, 1, S_NONE,      S_NONE,     1});
        tbl.push_back('{"load3",   4, 3, 0, 2, s_load(3'd3), S_NONE,    1});
        tbl.push_back('{"dup1",    3, 0, 0, 2, S_SPILL,     S_NONE,     2});
        tbl.push_back('{"push_s0", 1, 0, 3, 1, S_NONE,      S_NONE,     2});
        tbl.push_back('{"push_d2", 1, 2, 0, 3, S_SPILL,     s_load(3'd2), 3});
        tbl.push_back('{"flush3",  5, 0, 0, 2, S_FLUSH,     S_NONE,     0});
        tbl.push_back('{"flush0",  5, 0, 0, 2, S_FLUSH,     S_NONE,     0});

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst/ready", 32'(cmd_ready), 32'd1);
        chk("rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst/depth", 32'(depth), 32'd0);
        chk("rst/empty", 32'(empty), 32'd1);
        chk("rst/full", 32'(full), 32'd0);
        chk("rst/strobes", 32'(sig()), 32'd0);
        reset = 1'b1;

        foreach (tbl[i])
            do_cmd(tbl[i].nm, tbl[i].op, tbl[i].src, tbl[i].err, tbl[i].lat,
                   tbl[i].s0, tbl[i].s1, tbl[i].dep);

        // Reset asserted in the middle of a PUSH sequence
        do_cmd("pre_a", 3'd1, 3'd1, 2'd0, 2, s_load(3'd1), S_NONE, 1);
        do_cmd("pre_b", 3'd1, 3'd2, 2'd0, 3, S_SPILL, s_load(3'd2), 2);
        @(negedge CLK);
        cmd_op = 3'd1; cmd_src = 3'd3; cmd_valid = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        #2;
        chk("mid/spill_seen", 32'(sig()), 32'(S_SPILL));
        reset = 1'b0;
        #1;
        chk("mid/strobes_off", 32'(sig()), 32'd0);
        chk("mid/resp_valid", 32'(resp_valid), 32'd0);
        chk("mid/ready", 32'(cmd_ready), 32'd1);
        chk("mid/depth", 32'(depth), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("mid/no_resp", 32'(resp_valid), 32'd0);
        end
`ifdef DSCTRL_STATS_EN
        chk("mid/hwm", 32'(hwm), 32'd0);
        chk("mid/ops_done", 32'(ops_done), 32'd0);
`endif
        reset = 1'b1;
        @(negedge CLK);
        chk("rel/ready", 32'(cmd_ready), 32'd1);
        chk("rel/depth", 32'(depth), 32'd0);
        chk("rel/resp_valid", 32'(resp_valid), 32'd0);

        do_cmd("post0", 3'd1, 3'd4, 2'd0, 2, s_load(3'd4), S_NONE, 1);
        do_cmd("post1", 3'd1, 3'd3, 2'd0, 3, S_SPILL, s_load(3'd3), 2);
        do_cmd("post2", 3'd1, 3'd2, 2'd0, 3, S_SPILL, s_load(3'd2), 3);
`ifdef DSCTRL_STATS_EN
        chk("stats/hwm", 32'(hwm), 32'd3);
        chk("stats/ops_done", 32'(ops_done), 32'd3);
        do_cmd("post_pop", 3'd2, 3'd0, 2'd0, 3, S_FILL, S_DEC, 2);
        chk("stats/hwm_hold", 32'(hwm), 32'd3);
        chk("stats/ops_done4", 32'(ops_done), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
